uart_rx_engine: RTL

//  Serial-to-parallel UART receiver (8N1, LSB first) for the chip's uart_rx pin.
//  It is the receive-side counterpart of the UART transmitter: it samples the async pin,

---
 rtl/uart_rx_engine_pkg.sv | 21 ++
 rtl/uart_rx_engine_if.sv | 37 +++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_engine.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_rx_engine_pkg.sv
// Shared UART receive definitions: FSM state encoding, default baud divider and frame width.
// The optional even-parity frame is selected with UART_RX_PARITY_EN.
package uart_rx_engine_pkg;

    localparam int UART_DIV_RATE = 260;  // 10 MHz / 38400 baud
    localparam int UART_DATA_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Counter width that still holds n-1 when n is 1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Receive-side bus between the UART pin, the receiver engine and the register slave.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_engine_if #(
    parameter int DATA_W = uart_rx_engine_pkg::UART_DATA_W
);
    logic                          rx;
    logic [DATA_W-1:0]             rx_data;
    logic                          rx_end;
    logic                          rx_busy;
    logic                          frame_err;
`ifdef UART_RX_PARITY_EN
    logic                          parity_err;
`endif
    uart_rx_engine_pkg::rx_state_t state;

    // rx_end is a one-cycle valid with no ready: rx_data and the error flags are
    // updated on that cycle and held until the next rx_end, so the consumer must
    // capture them then. state is a debug view of the receiver FSM.
    modport master (
        input  rx,
        output rx_data, rx_end, rx_busy, frame_err,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output state
    );

    modport slave (
        output rx,
        input  rx_data, rx_end, rx_busy, frame_err,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  state
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; both flops reset to the idle-high level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: 8N1 (or 8E1 with UART_RX_PARITY_EN), LSB first, mid-bit sampling,
// one-cycle rx_end pulse per frame with registered data and error flags.
module uart_rx_engine
    import uart_rx_engine_pkg::*;
#(
    parameter int DIV_RATE = UART_DIV_RATE,
    parameter int DATA_W   = UART_DATA_W
) (
    input logic               clk,
    input logic               reset,
    uart_rx_engine_if.master  bus
);

    localparam int DCW = cnt_w(DIV_RATE);
    localparam int BCW = cnt_w(DATA_W);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_RATE - 1);
    localparam logic [DCW-1:0] DIV_HALF = DCW'(DIV_RATE / 2 - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);

    logic              w_rx_s;
    logic              r_rx_prev;
    rx_state_t         r_state;
    logic [DCW-1:0]    r_div;
    logic [BCW-1:0]    r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_stop_bit;
    logic              r_stop_seen;
    logic [DATA_W-1:0] r_data;
    logic              r_end;
    logic              r_busy;
    logic              r_ferr;
`ifdef UART_RX_PARITY_EN
    logic              r_par_bit;
    logic              r_perr;
`endif

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.rx),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_prev   <= 1'b1;
            r_state     <= ST_IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_stop_bit  <= 1'b1;
            r_stop_seen <= 1'b0;
            r_data      <= '0;
            r_end       <= 1'b0;
            r_busy      <= 1'b0;
            r_ferr      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= 1'b0;
            r_perr      <= 1'b0;
`endif
        end else begin
            r_rx_prev <= w_rx_s;
            r_end     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        r_state <= ST_START;
                        r_div   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    // Half a bit in: a line already back high was a glitch, not a start bit.
                    if (r_div == DIV_HALF) begin
                        r_div <= '0;
                        if (!w_rx_s) begin
                            r_state <= ST_DATA;
                            r_bit   <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_W-1:1]};
                        if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (r_div == DIV_LAST) begin
                        r_div     <= '0;
                        r_par_bit <= w_rx_s;
                        r_state   <= ST_STOP;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    // Stop bit is captured mid-bit; results are published on the following edge.
                    if (r_stop_seen) begin
                        r_stop_seen <= 1'b0;
                        r_data      <= r_shift;
                        r_ferr      <= ~r_stop_bit;
`ifdef UART_RX_PARITY_EN
                        r_perr      <= (^r_shift) ^ r_par_bit;
`endif
                        r_end       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (r_div == DIV_LAST) begin
                        r_div       <= '0;
                        r_stop_bit  <= w_rx_s;
                        r_stop_seen <= 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = r_data;
    assign bus.rx_end    = r_end;
    assign bus.rx_busy   = r_busy;
    assign bus.frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_perr;
`endif
    assign bus.state     = r_state;

endmodule
